// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] operand_a_in,
    input  logic [XLEN-1:0] operand_b_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            kill_in,
    output logic            stall_out,
    output logic            busy_out,
    output logic            result_valid_out,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_addr_out
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd;
    logic [4:0]          r_rd_out;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_b;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_result;

    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_rem_sh;
    logic                w_ge;
    logic [XLEN-1:0]     w_rem_sub;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    // Operand decode for the accept cycle
    always_comb begin
        w_is_div   = funct3_in[2];
        w_a_signed = (funct3_in == 3'b001) || (funct3_in == 3'b010) ||
                     (funct3_in == 3'b100) || (funct3_in == 3'b110);
        w_b_signed = (funct3_in == 3'b001) || (funct3_in == 3'b100) || (funct3_in == 3'b110);
        w_sa       = w_a_signed & operand_a_in[XLEN-1];
        w_sb       = w_b_signed & operand_b_in[XLEN-1];
        w_mag_a    = w_sa ? -operand_a_in : operand_a_in;
        w_mag_b    = w_sb ? -operand_b_in : operand_b_in;
        w_div_zero = w_is_div && (operand_b_in == '0);
        w_ovf      = w_is_div && !funct3_in[0] && (operand_b_in == '1) &&
                     (operand_a_in == {1'b1, {(XLEN-1){1'b0}}});
        w_special  = w_div_zero | w_ovf;
        if (w_div_zero) begin
            w_special_res = funct3_in[1] ? operand_a_in : '1;
        end else begin
            w_special_res = funct3_in[1] ? '0 : operand_a_in;
        end
    end

    // One iteration step; the shifted partial remainder needs XLEN+1 bits
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
        w_ge       = w_rem_sh >= {1'b0, r_b};
        w_rem_sub  = w_rem_sh[XLEN-1:0] - r_b;
        w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
        w_acc_next = r_funct3[2] ? w_div_next : w_mul_next;
        w_prod     = r_neg_q ? -w_acc_next : w_acc_next;
        w_quot     = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
        w_rem      = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
        case (r_funct3)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_rem;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (start_in) begin
                    w_state_nxt = w_special ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (r_cnt == '0) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (kill_in) begin
            w_state_nxt = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_rd_out <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!kill_in) begin
                if (r_state == StIdle && start_in) begin
                    r_funct3 <= funct3_in;
                    r_rd     <= rd_addr_in;
                    r_neg_q  <= w_sa ^ w_sb;
                    r_neg_r  <= w_sa;
                    if (w_special) begin
                        r_result <= w_special_res;
                        r_rd_out <= rd_addr_in;
                    end else begin
                        r_cnt <= CW'(XLEN - 1);
                        r_acc <= {{XLEN{1'b0}}, w_mag_a};
                        r_b   <= w_mag_b;
                    end
                end else if (r_state == StCalc) begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                    end
                end
            end
        end
    end

    always_comb begin
        busy_out         = (r_state != StIdle);
        result_valid_out = (r_state == StDone) && !kill_in;
        stall_out        = start_in && !result_valid_out;
        result_out       = r_result;
        rd_addr_out      = r_rd_out;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit (XLEN = 32): results, latency, stall, kill and reset.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start_in;
    logic [2:0]  funct3_in;
    logic [31:0] operand_a_in;
    logic [31:0] operand_b_in;
    logic [4:0]  rd_addr_in;
    logic        kill_in;
    logic        stall_out;
    logic        busy_out;
    logic        result_valid_out;
    logic [31:0] result_out;
    logic [4:0]  rd_addr_out;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_in         (start_in),
        .funct3_in        (funct3_in),
        .operand_a_in     (operand_a_in),
        .operand_b_in     (operand_b_in),
        .rd_addr_in       (rd_addr_in),
        .kill_in          (kill_in),
        .stall_out        (stall_out),
        .busy_out         (busy_out),
        .result_valid_out (result_valid_out),
        .result_out       (result_out),
        .rd_addr_out      (rd_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts an op in the next cycle (cycle 0), scrambles the inputs afterwards and
    // checks latency, stall/busy profile, result, rd and the return to idle.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit prof_ok;
        lat = -1;
        prof_ok = 1'b1;
        next_cycle();
        start_in     = 1'b1;
        funct3_in    = f3;
        operand_a_in = a;
        operand_b_in = b;
        rd_addr_in   = rd;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (result_valid_out) begin
                lat = n;
                if (stall_out !== 1'b0 || busy_out !== 1'b1) prof_ok = 1'b0;
                break;
            end
            if (stall_out !== 1'b1 || busy_out !== 1'(n > 0)) prof_ok = 1'b0;
            next_cycle();
            operand_a_in = ~a;
            operand_b_in = b ^ 32'h5a5a_5a5a;
            rd_addr_in   = ~rd;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(result_out), 64'(exp_res));
        check({tag, "_rd"}, 64'(rd_addr_out), 64'(rd));
        check({tag, "_stall_busy"}, 64'(prof_ok), 64'd1);
        next_cycle();
        start_in = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after"}, {62'd0, result_valid_out, busy_out}, 64'd0);
        check({tag, "_result_hold"}, 64'(result_out), 64'(exp_res));
    endtask

    initial begin
        int  beats;
        int  beat_cyc [2];
        bit  seen;

        rst          = 1'b1;
        start_in     = 1'b0;
        funct3_in    = 3'b000;
        operand_a_in = '0;
        operand_b_in = '0;
        rd_addr_in   = '0;
        kill_in      = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_busy", 64'(busy_out), 64'd0);
        check("reset_valid", 64'(result_valid_out), 64'd0);
        check("reset_stall", 64'(stall_out), 64'd0);
        check("reset_result", 64'(result_out), 64'd0);
        check("reset_rd", 64'(rd_addr_out), 64'd0);
        next_cycle();
        rst = 1'b0;

        run_op("mul_7_m3", 3'b000, 32'd7, 32'hffff_fffd, 5'd5, 32'hffff_ffeb, 33);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33);
        run_op("mulhu_max", 3'b011, 32'hffff_ffff, 32'hffff_ffff, 5'd7, 32'hffff_fffe, 33);
        run_op("mulhsu_m1", 3'b010, 32'hffff_ffff, 32'd2, 5'd8, 32'hffff_ffff, 33);
        run_op("div_m7_2", 3'b100, 32'hffff_fff9, 32'd2, 5'd9, 32'hffff_fffd, 33);
        run_op("rem_m7_2", 3'b110, 32'hffff_fff9, 32'd2, 5'd10, 32'hffff_ffff, 33);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 33);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 33);
        run_op("div_by0", 3'b100, 32'd5, 32'd0, 5'd13, 32'hffff_ffff, 1);
        run_op("remu_by0", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hffff_ffff, 5'd15, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hffff_ffff, 5'd16, 32'd0, 1);

        // Kill in cycle 10 of a DIV
        seen = 1'b0;
        next_cycle();
        start_in     = 1'b1;
        funct3_in    = 3'b100;
        operand_a_in = 32'd1000;
        operand_b_in = 32'd3;
        rd_addr_in   = 5'd20;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (result_valid_out) seen = 1'b1;
            next_cycle();
        end
        kill_in = 1'b1;
        @(negedge clk);
        if (result_valid_out) seen = 1'b1;
        next_cycle();
        kill_in  = 1'b0;
        start_in = 1'b0;
        @(negedge clk);
        check("kill_busy", 64'(busy_out), 64'd0);
        check("kill_no_valid", 64'({seen, result_valid_out}), 64'd0);
        run_op("mul_after_kill", 3'b000, 32'd12, 32'd13, 5'd21, 32'd156, 33);

        // Kill in the DONE cycle suppresses the beat
        next_cycle();
        start_in     = 1'b1;
        funct3_in    = 3'b101;
        operand_a_in = 32'd9;
        operand_b_in = 32'd0;
        rd_addr_in   = 5'd22;
        next_cycle();
        kill_in = 1'b1;
        @(negedge clk);
        check("kill_done_valid", 64'(result_valid_out), 64'd0);
        next_cycle();
        kill_in  = 1'b0;
        start_in = 1'b0;
        @(negedge clk);
        check("kill_done_busy", 64'({busy_out, result_valid_out}), 64'd0);

        // Reset in cycle 5 of a MUL
        next_cycle();
        start_in     = 1'b1;
        funct3_in    = 3'b000;
        operand_a_in = 32'd3;
        operand_b_in = 32'd4;
        rd_addr_in   = 5'd23;
        for (int n = 0; n < 5; n++) next_cycle();
        rst      = 1'b1;
        start_in = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs",
              {27'd0, busy_out, result_valid_out, stall_out, rd_addr_out, result_out},
              64'd0);

        // Back-to-back MULs with start_in held through DONE
        beats = 0;
        beat_cyc[0] = -1;
        beat_cyc[1] = -1;
        next_cycle();
        start_in     = 1'b1;
        funct3_in    = 3'b000;
        operand_a_in = 32'd3;
        operand_b_in = 32'd5;
        rd_addr_in   = 5'd24;
        for (int n = 0; n <= 80; n++) begin
            @(negedge clk);
            if (result_valid_out) begin
                beat_cyc[beats] = n;
                check($sformatf("b2b_result%0d", beats), 64'(result_out),
                      (beats == 0) ? 64'd15 : 64'd42);
                beats++;
                if (beats == 2) break;
            end
            next_cycle();
            if (beats == 1) begin
                operand_a_in = 32'd6;
                operand_b_in = 32'd7;
                rd_addr_in   = 5'd25;
            end
        end
        next_cycle();
        start_in = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (result_valid_out) beats++;
        end
        check("b2b_beats", 64'(beats), 64'd2);
        check("b2b_first_cycle", 64'(beat_cyc[0]), 64'd33);
        check("b2b_second_cycle", 64'(beat_cyc[1]), 64'd67);
        check("b2b_rd", 64'(rd_addr_out), 64'd25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M/RV64M multiply/divide execution unit. It sits beside the EX-stage ALU and takes the already-forwarded operands from EX. It runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While it works, it holds the ID/EX register through a combinational stall request to the hazard unit, then returns one result beat to the EX/MEM register.

## Interface
Parameters:
- XLEN, 32, operand/result width (32 or 64).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  EX holds an M-extension op; stays high while EX is stalled.
- funct3_in  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a_in  in  XLEN  rs1 value (post-forwarding).
- operand_b_in  in  XLEN  rs2 value (post-forwarding).
- rd_addr_in  in  5  destination register.
- kill_in  in  1  pipeline flush; aborts any operation.
- stall_out  out  1  hold IF/ID and ID/EX this cycle.
- busy_out  out  1  state is not IDLE.
- result_valid_out  out  1  one-cycle result beat.
- result_out  out  XLEN  result.
- rd_addr_out  out  5  destination register of the result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start_in & ~kill_in → latch funct3, rd, operands and sign flags.
  - Special case → DONE directly.
  - Otherwise → CALC with iteration counter = XLEN-1.
- CALC: one iteration per cycle.
  - Counter decrements each cycle.
  - At counter 0 → DONE after that iteration.
- DONE: result_valid_out = 1 for exactly this cycle, then → IDLE unconditionally.
  - start_in high in DONE is not accepted (it belongs to the same instruction, which advances this cycle).
- stall_out = start_in & ~result_valid_out (combinational).
- Multiply: shift-add over a 2·XLEN accumulator.
  - Signed operands (MULH: a and b; MULHSU: a only) are converted to magnitudes first.
  - Product is negated at the end if the signs differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring division on magnitudes, one quotient bit per cycle.
  - Quotient is negative iff the operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
- Special cases, resolved in IDLE without iterating:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (DIV/REM, a = 0x80…0, b = all ones): DIV → a; REM → 0.
- kill_in has priority over everything.
  - Any state → IDLE on next edge.
  - No result_valid_out, no operand capture.
  - A kill in DONE suppresses result_valid_out combinationally in that cycle.
- result_out and rd_addr_out update only on entry to DONE and hold until the next DONE.
- Operands are sampled once at accept; later changes on the inputs are ignored.

## Timing
- Reset: state IDLE, counter 0, accumulators 0.
  - stall_out = 0 is guaranteed only while start_in = 0.
  - busy_out = 0, result_valid_out = 0, result_out = 0, rd_addr_out = 0.
- Latency, with start_in high in IDLE in cycle c:
  - Iterative ops: result_valid_out high in cycle c+XLEN+1 (c+33 for XLEN = 32).
  - Special cases: result_valid_out high in cycle c+1.
- stall_out is high from cycle c through the cycle before DONE, and low in the DONE cycle, so EX/MEM captures the result on the DONE edge.
- Back-to-back M-ops: the next op is accepted in the IDLE cycle after DONE, i.e. one bubble-free stall cycle.
- Throughput: one op per XLEN+2 cycles.
- rst asserted mid-CALC or in DONE: all state and outputs return to reset values on that edge; the in-flight op is lost.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), start at cycle 0:
  - stall_out high in cycles 0–32.
  - result_valid_out only in cycle 33, result 0xFFFFFFEB, rd_addr_out = rd_addr_in.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Divides:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Each completes at cycle 33.
- Special cases, each result_valid_out at cycle 1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- kill_in in cycle 10 of a DIV:
  - IDLE and busy_out = 0 in cycle 11; no result_valid_out ever.
  - A new MUL started in cycle 12 completes in cycle 45.
- rst in cycle 5 of a MUL: all outputs 0 in cycle 6.
  - Back-to-back MULs with start_in held through DONE: exactly two result beats, at cycles 33 and 67.
